// File: rtl/hdmi_capture_ctrl.sv
// Single-frame HDMI window capture: waits for link ready and a vsync rise, then
// forwards in-window pixels to a FIFO with one cycle of latency.
module hdmi_capture_ctrl #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cfg_x0,
  input  logic [CNT_W-1:0] cfg_y0,
  input  logic [CNT_W-1:0] cfg_w,
  input  logic [CNT_W-1:0] cfg_h,
  input  logic             cmd_start,
  input  logic             cmd_abort,
  input  logic             hdmi_ready,
  input  logic             vsync,
  input  logic             de,
  input  logic [23:0]      pix_in,
  input  logic             fifo_full,
  output logic [23:0]      fifo_data,
  output logic             fifo_wr_en,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             short_frame
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_READY, S_WAIT_VSYNC, S_CAPTURE, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
  logic [CNT_W-1:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic             vsync_q, vsync_d, de_q, de_d;
  logic [23:0]      fifo_data_q, fifo_data_d;
  logic             fifo_wr_en_q, fifo_wr_en_d;
  logic             overflow_q, overflow_d, short_frame_q, short_frame_d;

  logic             vs_rise, de_fall, in_win, last_row;
  logic [CNT_W:0]   x_end, y_end;

  // Window bounds are one bit wider so x0+w never wraps back into range.
  always_comb begin
    vs_rise  = vsync & ~vsync_q;
    de_fall  = ~de & de_q;
    x_end    = {1'b0, x0_q} + {1'b0, w_q};
    y_end    = {1'b0, y0_q} + {1'b0, h_q};
    in_win   = ({1'b0, x_cnt_q} >= {1'b0, x0_q}) && ({1'b0, x_cnt_q} < x_end) &&
               ({1'b0, y_cnt_q} >= {1'b0, y0_q}) && ({1'b0, y_cnt_q} < y_end);
    last_row = (({1'b0, y_cnt_q} + 1'b1) == y_end);
  end

  always_comb begin
    state_d       = state_q;
    x0_d          = x0_q;
    y0_d          = y0_q;
    w_d           = w_q;
    h_d           = h_q;
    x_cnt_d       = x_cnt_q;
    y_cnt_d       = y_cnt_q;
    vsync_d       = vsync;
    de_d          = de;
    fifo_data_d   = fifo_data_q;
    fifo_wr_en_d  = 1'b0;
    overflow_d    = overflow_q;
    short_frame_d = short_frame_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          x0_d          = cfg_x0;
          y0_d          = cfg_y0;
          w_d           = cfg_w;
          h_d           = cfg_h;
          overflow_d    = 1'b0;
          short_frame_d = 1'b0;
          state_d       = S_WAIT_READY;
        end
      end
      S_WAIT_READY: begin
        if (hdmi_ready) state_d = S_WAIT_VSYNC;
      end
      S_WAIT_VSYNC: begin
        if (vs_rise) begin
          x_cnt_d = '0;
          y_cnt_d = '0;
          state_d = ((w_q == '0) || (h_q == '0)) ? S_DONE : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (de) begin
          if (!(&x_cnt_q)) x_cnt_d = x_cnt_q + 1'b1;
          if (in_win) begin
            if (fifo_full) begin
              overflow_d = 1'b1;
            end else begin
              fifo_wr_en_d = 1'b1;
              fifo_data_d  = pix_in;
            end
          end
        end
        // A completed last row takes precedence over a coincident vsync rise.
        if (de_fall) begin
          x_cnt_d = '0;
          if (!(&y_cnt_q)) y_cnt_d = y_cnt_q + 1'b1;
          if (last_row) state_d = S_DONE;
        end else if (vs_rise) begin
          short_frame_d = 1'b1;
          state_d       = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (cmd_abort && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      fifo_wr_en_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      x0_q          <= '0;
      y0_q          <= '0;
      w_q           <= '0;
      h_q           <= '0;
      x_cnt_q       <= '0;
      y_cnt_q       <= '0;
      vsync_q       <= 1'b0;
      de_q          <= 1'b0;
      fifo_data_q   <= '0;
      fifo_wr_en_q  <= 1'b0;
      overflow_q    <= 1'b0;
      short_frame_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      x0_q          <= x0_d;
      y0_q          <= y0_d;
      w_q           <= w_d;
      h_q           <= h_d;
      x_cnt_q       <= x_cnt_d;
      y_cnt_q       <= y_cnt_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      fifo_data_q   <= fifo_data_d;
      fifo_wr_en_q  <= fifo_wr_en_d;
      overflow_q    <= overflow_d;
      short_frame_q <= short_frame_d;
    end
  end

  assign fifo_data   = fifo_data_q;
  assign fifo_wr_en  = fifo_wr_en_q;
  assign overflow    = overflow_q;
  assign short_frame = short_frame_q;
  assign done        = (state_q == S_DONE);
  assign busy        = (state_q == S_WAIT_READY) || (state_q == S_WAIT_VSYNC) ||
                       (state_q == S_CAPTURE);

endmodule
